// File: rtl/dmem_responder.sv
// Data-memory responder for the single-cycle core: combinational load path,
// one-edge stores, a post-reset clear engine, misalignment flagging and a store counter.
module dmem_responder #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        misaligned,
    output logic        err_sticky,
    output logic [15:0] wr_count
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state_reg;
    logic [ADDR_W-1:0]   clr_ptr_reg;
    logic                ready_reg;
    logic                err_sticky_reg;
    logic [15:0]         wr_count_reg;
    logic [31:0]         mem [DEPTH];

    logic [ADDR_W-1:0]   idx;
    logic                aligned;
    logic                commit;
    logic                unused_addr_bits;

    // Upper address bits alias onto the array, so they are intentionally dropped.
    assign idx              = addr[ADDR_W+1:2];
    assign aligned          = (addr[1:0] == 2'b00);
    assign unused_addr_bits = ^addr[31:ADDR_W+2];
    assign commit           = (state_reg == RUN) && memwrite && aligned;

    assign misaligned = (state_reg == RUN) && !aligned;
    assign readdata   = ((state_reg == RUN) && aligned) ? mem[idx] : 32'h0000_0000;
    assign ready      = ready_reg;
    assign err_sticky = err_sticky_reg;
    assign wr_count   = wr_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= CLEAR;
            clr_ptr_reg    <= '0;
            ready_reg      <= 1'b0;
            err_sticky_reg <= 1'b0;
            wr_count_reg   <= 16'h0000;
        end else begin
            case (state_reg)
                CLEAR: begin
                    clr_ptr_reg <= clr_ptr_reg + ADDR_W'(1);
                    if (clr_ptr_reg == ADDR_W'(DEPTH - 1)) begin
                        state_reg <= RUN;
                        ready_reg <= 1'b1;
                    end
                end
                RUN: begin
                    if (!aligned)
                        err_sticky_reg <= 1'b1;
                    if (commit && (wr_count_reg != 16'hFFFF))
                        wr_count_reg <= wr_count_reg + 16'd1;
                end
                default: begin
                    state_reg <= CLEAR;
                    ready_reg <= 1'b0;
                end
            endcase
        end
    end

    // Array has no reset; the clear engine owns it until RUN.
    always_ff @(posedge clk) begin
        if (state_reg == CLEAR)
            mem[clr_ptr_reg] <= 32'h0000_0000;
        else if (commit)
            mem[idx] <= writedata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder: the driver pushes expected
// per-cycle outputs from a reference model, a negedge monitor pops and compares.
module tb_dmem_responder;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        ready;
    logic        misaligned;
    logic        err_sticky;
    logic [15:0] wr_count;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .ADDR_W(6)) dut (
        .clk(clk), .reset(reset), .memwrite(memwrite), .addr(addr),
        .writedata(writedata), .readdata(readdata), .ready(ready),
        .misaligned(misaligned), .err_sticky(err_sticky), .wr_count(wr_count)
    );

    typedef struct {
        string       tag;
        logic        rdy;
        logic        mis;
        logic        err;
        logic [31:0] rd;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: memory image, edges since reset release, store count, error flag.
    logic [31:0] m_mem [DEPTH];
    int          m_edges;
    int          m_cnt;
    bit          m_err;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk({e.tag, ".ready"},      32'(ready),      32'(e.rdy));
            chk({e.tag, ".misaligned"}, 32'(misaligned), 32'(e.mis));
            chk({e.tag, ".err_sticky"}, 32'(err_sticky), 32'(e.err));
            chk({e.tag, ".readdata"},   readdata,        e.rd);
            chk({e.tag, ".wr_count"},   32'(wr_count),   32'(e.cnt));
            $display("%s addr=%h we=%0d rd=%h rdy=%0d mis=%0d err=%0d cnt=%0d",
                     e.tag, addr, memwrite, readdata, ready, misaligned, err_sticky, wr_count);
        end
    end

    task automatic do_reset(input int cycles, input string tag);
        exp_t e;
        reset = 1'b1;
        memwrite = 1'b0;
        m_edges = 0;
        m_cnt = 0;
        m_err = 0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        for (int i = 0; i < cycles; i++) begin
            e.tag = tag; e.rdy = 1'b0; e.mis = 1'b0; e.err = 1'b0;
            e.rd = 32'h0; e.cnt = 16'h0;
            q.push_back(e);
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input string tag);
        exp_t e;
        int   widx;
        bit   run;
        bit   mis;
        memwrite = we;
        addr = a;
        writedata = d;
        run  = (m_edges >= DEPTH);
        mis  = run && ((a % 4) != 0);
        widx = int'(a / 4) % DEPTH;
        e.tag = tag;
        e.rdy = run;
        e.mis = mis;
        e.err = m_err;
        e.rd  = (run && !mis) ? m_mem[widx] : 32'h0;
        e.cnt = 16'(m_cnt);
        q.push_back(e);
        @(posedge clk); #1;
        if (run) begin
            if (mis) m_err = 1;
            else if (we) begin
                m_mem[widx] = d;
                if (m_cnt < 65535) m_cnt++;
            end
        end
        if (m_edges < DEPTH) m_edges++;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 15)) << 2);
        if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
        return a;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge clk); #1;
        do_reset(3, "rst");
        // Stores during CLEAR must be ignored.
        for (int i = 0; i < 10; i++) step(1'b1, 32'h0, 32'hFFFF_FFFF, "clr_we");
        for (int i = 10; i < DEPTH; i++) step(1'b0, 32'h10, 32'h0, "clr");
        step(1'b0, 32'h10, 32'h0, "rd10");
        step(1'b0, 32'h0,  32'h0, "rd0");
        step(1'b1, 32'h8,   32'hDEAD_BEEF, "st8");
        step(1'b0, 32'h8,   32'h0, "rd8");
        step(1'b0, 32'h108, 32'h0, "alias108");
        step(1'b1, 32'h208, 32'h55AA_55AA, "st208");
        step(1'b0, 32'h8,   32'h0, "rd8b");
        step(1'b1, 32'h6,   32'h1234, "mis_st6");
        step(1'b0, 32'h4,   32'h0, "rd4");
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), rand_addr(), $urandom, "rand");
        // Reset in the middle of CLEAR restarts the sweep.
        do_reset(2, "rst2");
        for (int i = 0; i < 20; i++) step(1'b1, 32'h4, 32'hA5A5_A5A5, "clr2");
        do_reset(1, "rst3");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, "clr3");
        for (int i = 0; i < 3; i++) step(1'b1, 32'(i * 4 + 12), $urandom, "st3");
        step(1'b0, 32'h3, 32'h0, "mis_ld");
        step(1'b0, 32'hC, 32'h0, "rdC");
        do_reset(2, "rst_run");
        for (int i = 0; i < DEPTH; i++) step(1'b0, 32'h0, 32'h0, "clr4");
        for (int i = 0; i < DEPTH; i++)
            step(1'b0, ($urandom & 32'hFFFF_FF00) | 32'(i * 4), 32'h0, "sweep");
        @(negedge clk); #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
